// File: rtl/ball_timer_if.sv
// Control/status bundle between the Pong game controller (master) and ball_timer (slave).
interface ball_timer_if #(
  parameter int PW = 5
);
  // MAXTIME/SETTIME/HOLD are level-sampled on every rising CLK edge; TICK is a one-cycle pulse.
  logic          MAXTIME;
  logic          SETTIME;
  logic          HOLD;
  logic          TICK;
  logic [PW-1:0] PERIOD;
  logic          ATMIN;

  modport master (
    output MAXTIME, SETTIME, HOLD,
    input  TICK, PERIOD, ATMIN
  );

  modport slave (
    input  MAXTIME, SETTIME, HOLD,
    output TICK, PERIOD, ATMIN
  );
endinterface

// File: rtl/ball_timer.sv
// Ball pace generator: prescaler plus period countdown emitting a one-cycle TICK.
// Optional speed-up on SETTIME is enabled by defining BALL_TIMER_SPEEDUP_EN.
module ball_timer #(
  parameter int PRESCALE   = 500000,
  parameter int PERIOD_MAX = 16,
  parameter int PERIOD_MIN = 2,
  parameter int STEP       = 2,
  parameter int PW         = 5
) (
  input logic          CLK,
  input logic          CLRN,
  ball_timer_if.slave  bus
);

  localparam int              PRW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRW-1:0]  PRE_LAST = PRW'(PRESCALE - 1);
  localparam logic [PRW-1:0]  PRE_ONE  = PRW'(1);
  localparam logic [PW-1:0]   P_MAX    = PW'(PERIOD_MAX);
  localparam logic [PW-1:0]   P_MIN    = PW'(PERIOD_MIN);
  localparam logic [PW-1:0]   ONE      = PW'(1);

  if (PRESCALE < 1 || PERIOD_MIN < 1 || PERIOD_MIN > PERIOD_MAX ||
      STEP < 0 || PERIOD_MAX >= (1 << PW)) begin : g_bad_cfg
    $error("ball_timer: illegal parameter set");
  end

  logic [PRW-1:0] pre;
  logic [PW-1:0]  period;
  logic [PW-1:0]  count;
  logic           tick;
  logic           strobe;
  logic [PW-1:0]  next_period;

  assign strobe = (pre == PRE_LAST);

`ifdef BALL_TIMER_SPEEDUP_EN
  localparam logic [PW:0]   MIN_PLUS_STEP = (PW+1)'(PERIOD_MIN + STEP);
  localparam logic [PW-1:0] P_STEP        = PW'(STEP);

  // Clamp at PERIOD_MIN instead of subtracting so the period never wraps.
  always_comb begin
    next_period = period;
    if ({1'b0, period} < MIN_PLUS_STEP)
      next_period = P_MIN;
    else
      next_period = period - P_STEP;
  end
`else
  // Without speed-up, SETTIME only restarts the current period.
  always_comb begin
    next_period = period;
  end
`endif

  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      pre    <= '0;
      count  <= P_MAX - ONE;
      period <= P_MAX;
      tick   <= 1'b0;
    end else if (bus.MAXTIME) begin
      pre    <= '0;
      count  <= P_MAX - ONE;
      period <= P_MAX;
      tick   <= 1'b0;
    end else if (bus.SETTIME) begin
      pre    <= '0;
      count  <= next_period - ONE;
      period <= next_period;
      tick   <= 1'b0;
    end else if (bus.HOLD) begin
      tick   <= 1'b0;
    end else begin
      pre <= strobe ? '0 : pre + PRE_ONE;
      if (strobe && count == '0) begin
        tick  <= 1'b1;
        count <= period - ONE;
      end else if (strobe) begin
        tick  <= 1'b0;
        count <= count - ONE;
      end else begin
        tick  <= 1'b0;
      end
    end
  end

  assign bus.TICK   = tick;
  assign bus.PERIOD = period;
  assign bus.ATMIN  = (period == P_MIN);

endmodule

// File: tb/tb_ball_timer.sv
// Self-checking bench for ball_timer: cycle-budget reference model, directed pins, random traffic.
module tb_ball_timer;
  localparam int PRESCALE = 4;
  localparam int PMAX     = 8;
  localparam int PMIN     = 2;
  localparam int STEP     = 2;
  localparam int PW       = 4;

`ifdef BALL_TIMER_SPEEDUP_EN
  localparam int E1 = 6, E2 = 4, E3 = 2, E4 = 6;
  localparam int E3A = 1;
`else
  localparam int E1 = 8, E2 = 8, E3 = 8, E4 = 8;
  localparam int E3A = 0;
`endif

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ball_timer_if #(.PW(PW)) bus ();

  ball_timer #(
    .PRESCALE  (PRESCALE),
    .PERIOD_MAX(PMAX),
    .PERIOD_MIN(PMIN),
    .STEP      (STEP),
    .PW        (PW)
  ) dut (
    .CLK (clk),
    .CLRN(rst_n),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remaining CLK cycles until the next TICK, reloaded on restart.
  int m_period;
  int m_rem;
  int m_tick;
  logic [PW+1:0] exp_q[$];

  function automatic int sped_up(input int p);
`ifdef BALL_TIMER_SPEEDUP_EN
    return (p - STEP < PMIN) ? PMIN : p - STEP;
`else
    return p;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_period = PMAX;
      m_rem    = PMAX * PRESCALE;
      m_tick   = 0;
      if (clk) exp_q.push_back({1'b0, PW'(PMAX), 1'b0});
      else     exp_q.delete();
    end else begin
      if (bus.MAXTIME) begin
        m_period = PMAX;
        m_rem    = PMAX * PRESCALE;
        m_tick   = 0;
      end else if (bus.SETTIME) begin
        m_period = sped_up(m_period);
        m_rem    = m_period * PRESCALE;
        m_tick   = 0;
      end else if (bus.HOLD) begin
        m_tick = 0;
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          m_tick = 1;
          m_rem  = m_period * PRESCALE;
        end else begin
          m_tick = 0;
        end
      end
      exp_q.push_back({m_tick[0], PW'(m_period), m_period == PMIN});
    end
  end

  // scoreboard compare
  always @(negedge clk) begin
    logic [PW+1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("tick",   bus.TICK,   e[PW+1]);
      check("period", bus.PERIOD, e[PW:1]);
      check("atmin",  bus.ATMIN,  e[0]);
    end
  end

  // driver tasks
  task automatic step(input logic mx, input logic st, input logic hd);
    bus.MAXTIME = mx;
    bus.SETTIME = st;
    bus.HOLD    = hd;
    @(negedge clk);
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    bus.MAXTIME = 1'b0;
    bus.SETTIME = 1'b0;
    bus.HOLD    = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      n++;
      if (bus.TICK === 1'b1) break;
    end
  endtask

  initial begin
    int n;
    int r;
    logic mx, st, hd;
    bus.MAXTIME = 1'b0;
    bus.SETTIME = 1'b0;
    bus.HOLD    = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_period", bus.PERIOD, 8);
    check("reset_tick",   bus.TICK,   0);
    check("reset_atmin",  bus.ATMIN,  0);
    rst_n = 1'b1;

    wait_tick(n); check("first_tick_edges", n, 32);
    @(negedge clk); check("tick_width", bus.TICK, 0);
    wait_tick(n); check("tick_spacing", n, 31);

    step(0, 1, 0); check("settime1_period", bus.PERIOD, E1);
    wait_tick(n);  check("settime1_first_tick", n, E1 * PRESCALE);
    step(0, 1, 0); check("settime2_period", bus.PERIOD, E2);
    repeat (5) step(0, 0, 0);
    step(0, 1, 0); check("settime3_period", bus.PERIOD, E3);
    check("settime3_atmin", bus.ATMIN, E3A);
    wait_tick(n);  check("min_first_tick", n, E3 * PRESCALE);
    wait_tick(n);  check("min_spacing", n, E3 * PRESCALE);
    step(0, 1, 0); check("settime4_period", bus.PERIOD, E3);

    step(1, 0, 0); check("maxtime_period", bus.PERIOD, 8);
    check("maxtime_atmin", bus.ATMIN, 0);
    wait_tick(n);  check("maxtime_first_tick", n, 32);

    // HOLD for 10 cycles mid-period stretches the spacing by 10
    repeat (5)  step(0, 0, 0);
    repeat (10) step(0, 0, 1);
    wait_tick(n); check("hold_spacing", n + 15, 42);

    // SETTIME on the terminal strobe swallows that TICK
    repeat (31) step(0, 0, 0);
    step(0, 1, 0); check("lost_tick", bus.TICK, 0);
    wait_tick(n);  check("after_lost_tick", n, E4 * PRESCALE);

    step(0, 1, 0);
    step(1, 1, 0); check("max_wins_period", bus.PERIOD, 8);

    repeat (7) step(0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_tick",   bus.TICK,   0);
    check("async_reset_period", bus.PERIOD, 8);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_tick(n); check("post_reset_first_tick", n, 32);

    // randomized traffic, checked by the scoreboard every cycle
    for (int i = 0; i < 3000; i++) begin
      r  = $urandom_range(0, 199);
      mx = (r < 2);
      st = (r >= 2 && r < 8) || (r == 8);
      if (r == 8) mx = 1'b1;
      hd = ($urandom_range(0, 9) < 2);
      step(mx, st, hd);
    end
    step(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ball_timer.md
# ball_timer

Programmable game-pace generator for the Pong datapath. It divides the system clock into base strobes and emits a one-cycle `TICK` every `PERIOD` strobes. `TICK` is the step pulse that the game controller uses to advance the ball shift register. The controller drives `MAXTIME` to restore the slowest pace and `SETTIME` to speed the ball up after a successful return. Sits between `control` and the shift-register/score datapath.

## Interface

Parameters:
- `PRESCALE`, 500000: CLK cycles per base strobe; legal range ≥1.
- `PERIOD_MAX`, 16: slowest period, in base strobes.
- `PERIOD_MIN`, 2: fastest period, in base strobes; legal range 1 ≤ `PERIOD_MIN` ≤ `PERIOD_MAX`.
- `STEP`, 2: period decrement applied per `SETTIME`; ≥0.
- `PW`, 5: width of the period and count registers; `PERIOD_MAX` < 2^`PW`.

Ports:
- `CLK`  in  1  system clock; all state updates on its rising edge.
- `CLRN`  in  1  reset, asynchronous, active-low.
- `MAXTIME`  in  1  load slowest period and restart the timing.
- `SETTIME`  in  1  shorten the period by `STEP` and restart the timing.
- `HOLD`  in  1  freeze the prescaler and the countdown.
- `TICK`  out  1  registered pulse, one CLK cycle wide.
- `PERIOD`  out  `PW`  current period register value.
- `ATMIN`  out  1  high when `PERIOD` == `PERIOD_MIN`; combinational from the register.

## Operation

- Internal state:
  - `pre`: prescaler, counts 0..`PRESCALE`-1.
  - `period`: current period.
  - `count`: countdown, in base strobes.
  - `TICK`: output flop.
- `strobe` = (`pre` == `PRESCALE`-1). `pre` wraps to 0 on `strobe`.
- Per-edge priority, highest first:
  1. `MAXTIME`:
     - `period` <= `PERIOD_MAX`; `count` <= `PERIOD_MAX`-1; `pre` <= 0; `TICK` <= 0.
  2. `SETTIME`:
     - `p'` = (`period` < `PERIOD_MIN`+`STEP`) ? `PERIOD_MIN` : `period`-`STEP`. The compare prevents underflow; the subtract never wraps.
     - `period` <= `p'`; `count` <= `p'`-1; `pre` <= 0; `TICK` <= 0.
  3. `HOLD`:
     - `pre`, `count` and `period` hold their values; `TICK` <= 0.
  4. Otherwise:
     - `pre` advances.
     - On `strobe` with `count` == 0: `TICK` <= 1 and `count` <= `period`-1.
     - On `strobe` with `count` ≠ 0: `count` decrements and `TICK` <= 0.
     - Without `strobe`: `TICK` <= 0.
- `MAXTIME` together with `SETTIME`: `MAXTIME` wins.
- A `TICK` already high stays visible for its one cycle even if `MAXTIME`/`SETTIME` arrive in that cycle.
- If a `strobe` with `count` == 0 coincides with `MAXTIME`/`SETTIME`, no `TICK` is produced; the pending pulse is lost by design.
- Once `period` reaches `PERIOD_MIN`, further `SETTIME` pulses only restart the timing.

## Timing

- Reset (`CLRN`=0, asynchronous):
  - `pre`=0, `count`=`PERIOD_MAX`-1, `period`=`PERIOD_MAX`, `TICK`=0.
  - `ATMIN`=1 only if `PERIOD_MAX` == `PERIOD_MIN`.
  - Reset mid-count discards all progress.
- First `TICK` after a restart (reset release, `MAXTIME` or `SETTIME`): rises on the `period`×`PRESCALE`-th rising edge after the restart edge, with no `HOLD`.
- Steady-state `TICK` spacing is `period`×`PRESCALE` CLK cycles, rising edge to rising edge.
- `HOLD` asserted for N cycles delays the next `TICK` by exactly N cycles.
- Latency:
  - `PERIOD` and `ATMIN` reflect `MAXTIME`/`SETTIME` one edge after they are sampled.
  - `TICK` is one edge after the terminal `strobe`.
- `PRESCALE`=1: `strobe` is true every cycle, giving a `TICK` spacing of `period` cycles.

## Configuration

- Macro: `BALL_TIMER_SPEEDUP_EN`.
- Defined: `SETTIME` decrements `period` as specified above.
- Undefined:
  - `SETTIME` behaves as a restart only: `count` <= `period`-1, `pre` <= 0, `TICK` <= 0, and `period` is unchanged.
  - `period` therefore stays at `PERIOD_MAX`.
  - `ATMIN` is constant (`PERIOD_MAX` == `PERIOD_MIN`).

## Test plan

All scenarios use `PRESCALE`=4, `PERIOD_MAX`=8, `PERIOD_MIN`=2, `STEP`=2, `PW`=4, with the macro defined unless stated otherwise.

1. Reset, then release `CLRN` -> `PERIOD`=8 and `TICK`=0. First `TICK` on the 32nd edge after release, then every 32 cycles, each exactly 1 cycle wide.
2. Three single-cycle `SETTIME` pulses spaced 40 cycles apart -> `PERIOD` 6, 4, 2. After the third, `ATMIN`=1 and `TICK` spacing is 8 cycles. A fourth `SETTIME` leaves `PERIOD`=2.
3. At `PERIOD`=2, pulse `MAXTIME` -> `PERIOD`=8 and `ATMIN`=0 next edge. Next `TICK` is 32 edges after the `MAXTIME` edge.
4. Assert `MAXTIME` and `SETTIME` in the same cycle at `PERIOD`=4 -> `PERIOD`=8. Assert `SETTIME` on the terminal-strobe cycle -> no `TICK` that period.
5. `HOLD` high for 10 cycles mid-period -> the following `TICK` arrives 42 cycles after the previous one. Pull `CLRN` low mid-period -> `TICK`=0 and `PERIOD`=8 immediately.
6. Macro undefined: three `SETTIME` pulses -> `PERIOD` stays 8 and `ATMIN`=0. Each pulse restarts the 32-cycle spacing.
